mem_port_arbiter4: RTL and testbench

//  Shares one 64-bit memory port among four requesters (e.g. IF, MEM, debug, DMA).

---
 rtl/crane_bus_pkg.sv | 15 +
 rtl/mem_port_arbiter4_rr_pick4.sv | 26 ++
 rtl/mem_port_arbiter4.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter4.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/crane_bus_pkg.sv
// Shared types for the memory-port arbiter: FSM states, requester count, select width.
package crane_bus_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  function automatic logic [N_REQ-1:0] sel2oh(input logic [SEL_W-1:0] s);
    return N_REQ'(1) << s;
  endfunction
endpackage

// File: rtl/mem_port_arbiter4_rr_pick4.sv
// Combinational 4-way picker: round-robin from ptr, or fixed priority (index 0 highest).
module rr_pick4
  import crane_bus_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             fixed,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [SEL_W-1:0] w_start;
  logic [SEL_W-1:0] w_cand;

  assign w_start = fixed ? '0 : ptr;
  assign any     = |req;

  // Scan offsets high to low so the smallest offset from the start point wins.
  always_comb begin
    idx    = '0;
    w_cand = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      w_cand = w_start + SEL_W'(k);
      if (req[w_cand]) idx = w_cand;
    end
  end
endmodule

// File: rtl/mem_port_arbiter4.sv
// Four-requester memory-port arbiter: grant, issue, wait for response, return done/err to owner.
module mem_port_arbiter4
  import crane_bus_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_REQ-1:0] req,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             busy,
  output logic             mem_valid,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  output logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] err
);
  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e           r_state, w_state_nxt;
  logic [SEL_W-1:0] r_sel, w_sel_nxt;
  logic [N_REQ-1:0] r_grant, w_grant_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_mem_valid, w_mv_nxt;
  logic [N_REQ-1:0] r_done, w_done_nxt;
  logic [N_REQ-1:0] r_err, w_err_nxt;
  logic [SEL_W-1:0] r_rr_ptr, w_ptr_nxt;
  logic [TO_W-1:0]  r_to_cnt, w_to_nxt;
  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_to_hit;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (r_rr_ptr),
    .fixed (PRIO_MODE != 0),
    .any   (w_any),
    .idx   (w_idx)
  );

  assign w_to_hit = TO_EN && (r_to_cnt == TO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_sel       <= '0;
      r_grant     <= '0;
      r_busy      <= 1'b0;
      r_mem_valid <= 1'b0;
      r_done      <= '0;
      r_err       <= '0;
      r_rr_ptr    <= '0;
      r_to_cnt    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_grant     <= w_grant_nxt;
      r_busy      <= w_busy_nxt;
      r_mem_valid <= w_mv_nxt;
      r_done      <= w_done_nxt;
      r_err       <= w_err_nxt;
      r_rr_ptr    <= w_ptr_nxt;
      r_to_cnt    <= w_to_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_busy_nxt  = r_busy;
    w_mv_nxt    = r_mem_valid;
    w_done_nxt  = '0;
    w_err_nxt   = '0;
    w_ptr_nxt   = r_rr_ptr;
    w_to_nxt    = r_to_cnt;
    unique case (r_state)
      ST_IDLE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_mv_nxt    = 1'b0;
        if (w_any) begin
          w_state_nxt = ST_ISSUE;
          w_sel_nxt   = w_idx;
          w_grant_nxt = sel2oh(w_idx);
          w_busy_nxt  = 1'b1;
          w_mv_nxt    = 1'b1;
          w_to_nxt    = '0;
        end
      end
      ST_ISSUE: begin
        if (mem_ready) begin
          w_state_nxt = ST_WAIT;
          w_mv_nxt    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (!(&r_to_cnt)) w_to_nxt = r_to_cnt + TO_W'(1);
        // A response on the watchdog's last cycle still counts as a normal completion.
        if (mem_rvalid || w_to_hit) begin
          w_done_nxt  = mem_rvalid ? sel2oh(r_sel) : '0;
          w_err_nxt   = mem_rvalid ? '0 : sel2oh(r_sel);
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
          w_grant_nxt = '0;
          w_ptr_nxt   = r_sel + SEL_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign sel       = r_sel;
  assign grant     = r_grant;
  assign busy      = r_busy;
  assign mem_valid = r_mem_valid;
  assign done      = r_done;
  assign err       = r_err;
endmodule

// File: tb/tb_mem_port_arbiter4.sv
// Scoreboard bench: round-robin and fixed-priority arbiters share one stimulus stream.
module tb_mem_port_arbiter4;
  localparam int TO = 8;

  logic       clk, rstn, mem_ready, mem_rvalid;
  logic [3:0] req;
  logic [1:0] sel_r, sel_f;
  logic [3:0] grant_r, grant_f, done_r, done_f, err_r, err_f;
  logic       busy_r, busy_f, mv_r, mv_f;

  typedef struct { int wr; int wf; int cyc; bit is_err; } exp_t;
  exp_t gq[$];
  exp_t cq[$];
  int   n_tests = 0, n_fail = 0, cyc = 0, m_ptr = 0;
  int   cur_wr = 0, cur_wf = 0;
  bit   pb = 0;

  mem_port_arbiter4 #(.PRIO_MODE(0), .TIMEOUT(TO), .TO_W(8)) u_rr (
    .clk(clk), .rstn(rstn), .req(req), .sel(sel_r), .grant(grant_r), .busy(busy_r),
    .mem_valid(mv_r), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .done(done_r), .err(err_r));

  mem_port_arbiter4 #(.PRIO_MODE(1), .TIMEOUT(TO), .TO_W(8)) u_fx (
    .clk(clk), .rstn(rstn), .req(req), .sel(sel_f), .grant(grant_f), .busy(busy_f),
    .mem_valid(mv_f), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .done(done_f), .err(err_f));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference: first requester at or after the pointer, circularly.
  function automatic int rr_model(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++) if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  function automatic int fx_model(input logic [3:0] r);
    for (int i = 0; i < 4; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, "_rr"}, {sel_r, grant_r, 3'(busy_r), 3'(mv_r), done_r, err_r}, 32'h0);
    chk({nm, "_fx"}, {sel_f, grant_f, 3'(busy_f), 3'(mv_f), done_f, err_f}, 32'h0);
  endtask

  // Entered at 1 time unit after a rising edge; leaves at the same phase.
  // d = ready-low cycles in ISSUE, v = WAIT cycle of response (>= TO means none).
  task automatic run_txn(input logic [3:0] r, input int d, input int v, input bit rst_in_wait);
    exp_t e;
    req = r;
    e.wr = rr_model(r, m_ptr);
    e.wf = fx_model(r);
    e.cyc = cyc + 1;
    e.is_err = 1'b0;
    gq.push_back(e);
    @(posedge clk); #1;
    req = 4'($urandom);
    for (int k = 0; k < d; k++) begin
      chk("mv_backpressure", {31'd0, mv_r}, 32'd1);
      mem_ready = 1'b0;
      mem_rvalid = 1'($urandom);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    mem_rvalid = 1'b0;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    chk("mv_wait", {31'd0, mv_r}, 32'd0);
    for (int j = 0; j < TO; j++) begin
      if (rst_in_wait && j == 2) begin
        req = '0;
        #3 rstn = 1'b0;
        #1 chk_all_zero("async_reset");
        m_ptr = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        return;
      end
      if (j == v || j == TO - 1) begin
        mem_rvalid = (j == v);
        req = '0;
        e.cyc = cyc + 1;
        e.is_err = (j != v);
        cq.push_back(e);
        m_ptr = (e.wr + 1) % 4;
        @(posedge clk); #1;
        mem_rvalid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstn) begin
      if (busy_r && !pb) begin
        if (gq.size() == 0) chk("grant_unexpected", 32'd1, 32'd0);
        else begin
          e = gq.pop_front();
          cur_wr = e.wr;
          cur_wf = e.wf;
          chk("grant_rr", {28'd0, grant_r}, 32'(1) << e.wr);
          chk("grant_fx", {28'd0, grant_f}, 32'(1) << e.wf);
          chk("grant_cycle", cyc, e.cyc);
          chk("mv_on_grant", {30'd0, mv_r, mv_f}, 32'd3);
        end
      end
      if (busy_r) begin
        chk("sel_hold_rr", {30'd0, sel_r}, cur_wr);
        chk("sel_hold_fx", {30'd0, sel_f}, cur_wf);
        chk("busy_fx", {31'd0, busy_f}, 32'd1);
      end
      if (|{done_r, err_r, done_f, err_f}) begin
        if (cq.size() == 0) chk("completion_unexpected", {done_r, err_r, done_f, err_f}, 32'd0);
        else begin
          e = cq.pop_front();
          chk("done_rr", {28'd0, done_r}, e.is_err ? 32'd0 : 32'(1) << e.wr);
          chk("err_rr",  {28'd0, err_r},  e.is_err ? 32'(1) << e.wr : 32'd0);
          chk("done_fx", {28'd0, done_f}, e.is_err ? 32'd0 : 32'(1) << e.wf);
          chk("err_fx",  {28'd0, err_f},  e.is_err ? 32'(1) << e.wf : 32'd0);
          chk("completion_cycle", cyc, e.cyc);
          chk("idle_at_completion", {grant_r, 3'(busy_r), grant_f, 3'(busy_f)}, 32'd0);
        end
      end
      pb = busy_r;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, failed %0d", n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    req = '0;
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    #3 chk_all_zero("reset_state");
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    // RR fairness from pointer 0 with everyone requesting, minimal spacing.
    for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 0, 1'b0);
    run_txn(4'b0100, 0, 3, 1'b0);
    for (int i = 0; i < 4; i++) run_txn(4'b1010, 0, 1, 1'b0);
    run_txn(4'b0001, 5, 2, 1'b0);
    run_txn(4'b0110, 1, TO - 1, 1'b0);
    run_txn(4'b1001, 0, TO, 1'b0);
    run_txn(4'b1111, 2, TO + 1, 1'b0);
    for (int i = 0; i < 40; i++)
      run_txn(4'($urandom_range(1, 15)), $urandom_range(0, 5), $urandom_range(0, TO + 1), 1'b0);
    // Leave the pointer at 2, then reset mid-WAIT; 1010 must go to requester 1 afterwards.
    run_txn(4'b0010, 0, 0, 1'b0);
    run_txn(4'b0010, 0, TO + 1, 1'b1);
    run_txn(4'b1010, 0, 1, 1'b0);
    run_txn(4'b0001, 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("grant_queue_drained", gq.size(), 32'd0);
    chk("completion_queue_drained", cq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
